// File: rtl/axis_packet_combiner_pkg.sv
// Shared types and helpers for the AXI4-Stream packet combiner.
//   state_t     : framing state (SYNC / IDLE / ACTIVE)
//   clamp_count : maps a raw packets-per-frame setting onto the legal range 1..max_cnt
package axis_packet_combiner_pkg;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      IDLE   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   // A zero setting would never close a frame, so it is treated as 1.
   function automatic int clamp_count(input int cfg, input int max_cnt);
      if (cfg <= 0)
         return 1;
      else if (cfg > max_cnt)
         return max_cnt;
      return cfg;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic 2-entry registered AXI4-Stream slice.
// Ports:
//   i_aclk, i_aresetn        clock, asynchronous active-low reset
//   i_s_valid/o_s_ready/i_s_data   upstream handshake and payload
//   o_m_valid/i_m_ready/o_m_data   downstream handshake and payload
// o_s_ready comes straight from a flop (not full), so there is no combinational
// path from i_m_ready to o_s_ready. Entry 0 always drives the output.
module axis_skid_buffer #(
   parameter int WIDTH = 33
) (
   input  logic             i_aclk,
   input  logic             i_aresetn,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   input  logic [WIDTH-1:0] i_s_data,
   output logic             o_m_valid,
   input  logic             i_m_ready,
   output logic [WIDTH-1:0] o_m_data
);

   logic             r_valid0;
   logic             r_valid1;
   logic [WIDTH-1:0] r_data0;
   logic [WIDTH-1:0] r_data1;
   logic             w_push;
   logic             w_pop;

   assign w_push = i_s_valid & ~r_valid1;
   assign w_pop  = r_valid0 & i_m_ready;

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_valid0 <= 1'b0;
         r_valid1 <= 1'b0;
         r_data0  <= '0;
         r_data1  <= '0;
      end else begin
         if (r_valid1) begin
            // full: upstream is held off, only draining is possible
            if (w_pop) begin
               r_data0  <= r_data1;
               r_valid1 <= 1'b0;
            end
         end else if (r_valid0) begin
            if (w_push && w_pop) begin
               r_data0 <= i_s_data;
            end else if (w_pop) begin
               r_valid0 <= 1'b0;
            end else if (w_push) begin
               r_data1  <= i_s_data;
               r_valid1 <= 1'b1;
            end
         end else if (w_push) begin
            r_data0  <= i_s_data;
            r_valid0 <= 1'b1;
         end
      end
   end

   assign o_s_ready = ~r_valid1;
   assign o_m_valid = r_valid0;
   assign o_m_data  = r_data0;

endmodule

// File: rtl/axis_packet_combiner_rt.sv
// AXI4-Stream framer: merges cfg_count consecutive input packets into one output
// packet, with a registered 2-entry output slice and a frame counter.
// Ports:
//   axis_aclk, axis_aresetn    clock, asynchronous active-low reset
//   cfg_count, cfg_enable      packets per frame / enable, both sampled at frame start
//   s_axis_*                   input stream (tready is registered)
//   m_axis_*                   combined output stream
//   m_axis_tuser               start-of-frame flag, only with AXIS_PACKET_COMBINER_TUSER_SOF_EN
//   stat_frames, stat_busy     completed-frame count (wraps), in-frame indicator
// Optional build macro: AXIS_PACKET_COMBINER_TUSER_SOF_EN
//
// state  | meaning
// SYNC   | dropping beats until an input tlast re-aligns to a packet boundary
// IDLE   | at a frame boundary; next beat starts a frame or is dropped
// ACTIVE | inside a frame; every beat forwarded, tlasts counted down
module axis_packet_combiner_rt
   import axis_packet_combiner_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH     = 32,
   parameter int MAX_PACKETS          = 256,
   parameter int DISCARD_FIRST_PACKET = 1,
   localparam int COUNT_W             = $clog2(MAX_PACKETS + 1)
) (
   input  logic                        axis_aclk,
   input  logic                        axis_aresetn,
   input  logic [COUNT_W-1:0]          cfg_count,
   input  logic                        cfg_enable,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        s_axis_tlast,
   input  logic                        m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
`ifdef AXIS_PACKET_COMBINER_TUSER_SOF_EN
   output logic                        m_axis_tuser,
`endif
   output logic [31:0]                 stat_frames,
   output logic                        stat_busy
);

   localparam state_t             RESET_STATE = (DISCARD_FIRST_PACKET != 0) ? SYNC : IDLE;
   localparam logic [COUNT_W-1:0] ONE         = COUNT_W'(1);

`ifdef AXIS_PACKET_COMBINER_TUSER_SOF_EN
   localparam int BUF_W = AXIS_TDATA_WIDTH + 2;
`else
   localparam int BUF_W = AXIS_TDATA_WIDTH + 1;
`endif

   state_t               r_state;
   logic [COUNT_W-1:0]   r_remaining;
   logic                 r_stat_busy;
   logic [31:0]          r_stat_frames;

   logic [COUNT_W-1:0]   w_eff_m1;
   logic                 w_accept;
   logic                 w_fwd_sel;
   logic                 w_out_last;
   logic                 w_buf_s_ready;
   logic                 w_buf_s_valid;
   logic [BUF_W-1:0]     w_buf_in;
   logic [BUF_W-1:0]     w_buf_out;

   assign w_eff_m1      = COUNT_W'(clamp_count(int'(cfg_count), MAX_PACKETS) - 1);
   assign w_accept      = s_axis_tvalid & w_buf_s_ready;
   assign w_fwd_sel     = ((r_state == IDLE) & cfg_enable) | (r_state == ACTIVE);
   // in IDLE the frame length is taken live from cfg_count, in ACTIVE from the latched count
   assign w_out_last    = s_axis_tlast &
                          ((r_state == IDLE) ? (w_eff_m1 == '0) : (r_remaining == '0));
   // dropped beats never enter the buffer but still wait for its ready
   assign w_buf_s_valid = s_axis_tvalid & w_fwd_sel;
   assign s_axis_tready = w_buf_s_ready;

`ifdef AXIS_PACKET_COMBINER_TUSER_SOF_EN
   assign w_buf_in = {(r_state == IDLE), w_out_last, s_axis_tdata};
   assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = w_buf_out;
`else
   assign w_buf_in = {w_out_last, s_axis_tdata};
   assign {m_axis_tlast, m_axis_tdata} = w_buf_out;
`endif

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         r_state     <= RESET_STATE;
         r_remaining <= '0;
         r_stat_busy <= 1'b0;
      end else if (w_accept) begin
         case (r_state)
            SYNC: begin
               if (s_axis_tlast)
                  r_state <= IDLE;
            end
            IDLE: begin
               if (!cfg_enable) begin
                  if (!s_axis_tlast)
                     r_state <= SYNC;
               end else if (!(s_axis_tlast && (w_eff_m1 == '0))) begin
                  r_state     <= ACTIVE;
                  r_stat_busy <= 1'b1;
                  // a single-beat first packet already used up one of the packets
                  r_remaining <= s_axis_tlast ? (w_eff_m1 - ONE) : w_eff_m1;
               end
            end
            ACTIVE: begin
               if (s_axis_tlast) begin
                  if (r_remaining == '0) begin
                     r_state     <= IDLE;
                     r_stat_busy <= 1'b0;
                  end else begin
                     r_remaining <= r_remaining - ONE;
                  end
               end
            end
            default: begin
               r_state     <= RESET_STATE;
               r_stat_busy <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn)
         r_stat_frames <= '0;
      else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
         r_stat_frames <= r_stat_frames + 32'd1;
   end

   assign stat_frames = r_stat_frames;
   assign stat_busy   = r_stat_busy;

   axis_skid_buffer #(
      .WIDTH (BUF_W)
   ) u_out_slice (
      .i_aclk    (axis_aclk),
      .i_aresetn (axis_aresetn),
      .i_s_valid (w_buf_s_valid),
      .o_s_ready (w_buf_s_ready),
      .i_s_data  (w_buf_in),
      .o_m_valid (m_axis_tvalid),
      .i_m_ready (m_axis_tready),
      .o_m_data  (w_buf_out)
   );

endmodule

// File: tb/tb_axis_packet_combiner_rt.sv
// Testbench for axis_packet_combiner_rt (default parameters, DISCARD_FIRST_PACKET = 1).
// Directed scenarios plus randomized traffic, all checked against a packet-level
// reference model that tracks frames by counting completed input packets.
module tb_axis_packet_combiner_rt;

   localparam int DW = 32;
   localparam int CW = 9;

   logic          axis_aclk = 1'b0;
   logic          axis_aresetn;
   logic [CW-1:0] cfg_count;
   logic          cfg_enable;
   logic          s_axis_tready;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tvalid;
   logic          s_axis_tlast;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
`ifdef AXIS_PACKET_COMBINER_TUSER_SOF_EN
   logic          m_axis_tuser;
`endif
   logic [31:0]   stat_frames;
   logic          stat_busy;

   always #5 axis_aclk = ~axis_aclk;

   axis_packet_combiner_rt dut (
      .axis_aclk     (axis_aclk),
      .axis_aresetn  (axis_aresetn),
      .cfg_count     (cfg_count),
      .cfg_enable    (cfg_enable),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
`ifdef AXIS_PACKET_COMBINER_TUSER_SOF_EN
      .m_axis_tuser  (m_axis_tuser),
`endif
      .stat_frames   (stat_frames),
      .stat_busy     (stat_busy)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic          sof;
      logic          last;
      logic [DW-1:0] data;
   } exp_t;

   exp_t        exp_q[$];
   bit          md_sync;
   bit          md_inframe;
   int          md_pkts;
   int          md_n;
   logic [31:0] md_frames;

   function automatic int eff_count(input int cfg);
      if (cfg == 0) return 1;
      if (cfg > 256) return 256;
      return cfg;
   endfunction

   task automatic model_accept(input logic [DW-1:0] d, input logic last,
                               input int cfg, input logic en);
      exp_t e;
      if (md_sync) begin
         if (last) md_sync = 1'b0;
      end else if (!md_inframe && !en) begin
         if (!last) md_sync = 1'b1;
      end else begin
         e.sof = !md_inframe;
         if (!md_inframe) begin
            md_n       = eff_count(cfg);
            md_pkts    = 0;
            md_inframe = 1'b1;
         end
         e.last = last && (md_pkts + 1 == md_n);
         e.data = d;
         exp_q.push_back(e);
         if (last) begin
            md_pkts++;
            if (e.last) md_inframe = 1'b0;
         end
      end
   endtask

   // ---------------- monitor (negedge, away from the active edge) ----------------
   bit            prev_stall;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   always @(negedge axis_aclk) begin
      exp_t e;
      if (!axis_aresetn) begin
         exp_q.delete();
         md_sync    = 1'b1;
         md_inframe = 1'b0;
         md_pkts    = 0;
         md_n       = 1;
         md_frames  = '0;
         prev_stall = 1'b0;
      end else begin
         chk("m_tvalid_vs_model", m_axis_tvalid, exp_q.size() != 0);
         chk("s_tready_vs_model", s_axis_tready, exp_q.size() < 2);
         chk("stat_frames", stat_frames, md_frames);
         chk("stat_busy", stat_busy, md_inframe);
         if (prev_stall) begin
            chk("stall_valid_held", m_axis_tvalid, 1);
            chk("stall_data_held", m_axis_tdata, prev_data);
            chk("stall_last_held", m_axis_tlast, prev_last);
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL orphan_beat: got data 0x%0h last %0b, expected no beat", m_axis_tdata, m_axis_tlast);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", m_axis_tdata, e.data);
               chk("out_last", m_axis_tlast, e.last);
`ifdef AXIS_PACKET_COMBINER_TUSER_SOF_EN
               chk("out_tuser_sof", m_axis_tuser, e.sof);
`endif
            end
            if (m_axis_tlast) md_frames++;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
         if (s_axis_tvalid && s_axis_tready)
            model_accept(s_axis_tdata, s_axis_tlast, int'(cfg_count), cfg_enable);
      end
   end

   // ---------------- downstream ready driver ----------------
   bit rand_ready = 1'b0;

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge axis_aclk);
         #1;
         m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- stimulus helpers (all start/end at posedge+1) ----------------
   int beat_cycles = 0;

   task automatic send_beat(input logic last);
      int   waited;
      logic acc;
      waited        = 0;
      s_axis_tdata  = $urandom();
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      forever begin
         @(negedge axis_aclk);
         acc = s_axis_tready;
         @(posedge axis_aclk);
         #1;
         beat_cycles++;
         if (acc) break;
         waited++;
         if (waited > 500) begin
            n_checks++;
            n_err++;
            $display("FAIL beat_timeout: s_tready low for %0d cycles, required below 500", waited);
            break;
         end
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         @(posedge axis_aclk);
         #1;
      end
   endtask

   task automatic send_pkt(input int len, input int gap_max);
      for (int i = 0; i < len; i++) begin
         send_beat(i == len - 1);
         if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || m_axis_tvalid) && k < 2000) begin
         @(posedge axis_aclk);
         #1;
         k++;
      end
      if (k >= 2000) begin
         n_checks++;
         n_err++;
         $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", exp_q.size(), k);
      end
      idle(2);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      axis_aresetn  = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      cfg_count     = 9'd4;
      cfg_enable    = 1'b1;

      repeat (3) @(posedge axis_aclk);
      @(negedge axis_aclk);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tlast", m_axis_tlast, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_stat_frames", stat_frames, 0);
      chk("rst_stat_busy", stat_busy, 0);
      chk("rst_s_tready", s_axis_tready, 1);
      @(posedge axis_aclk);
      #1;
      axis_aresetn = 1'b1;

      // stream joins mid-packet: beats 5..7 of an 8-beat packet are dropped
      send_beat(1'b0);
      send_beat(1'b0);
      send_beat(1'b1);
      idle(3);
      chk("sync_drop_no_valid", m_axis_tvalid, 0);
      chk("sync_drop_not_busy", stat_busy, 0);

      // 4 packets of 8 beats per frame, back to back, full throughput
      beat_cycles = 0;
      for (int p = 0; p < 8; p++) send_pkt(8, 0);
      chk("throughput_cycles_64", beat_cycles, 64);
      drain();
      chk("frames_after_64", stat_frames, 2);

      // cfg_count 0 behaves as 1
      cfg_count = 9'd0;
      for (int p = 0; p < 10; p++) send_pkt(1, 0);
      drain();
      chk("frames_count0", stat_frames, 12);

      // cfg_count 300 clamps to 256
      cfg_count = 9'd300;
      for (int p = 0; p < 255; p++) send_pkt(1, 0);
      drain();
      chk("clamp_busy_at_255", stat_busy, 1);
      chk("clamp_frames_at_255", stat_frames, 12);
      send_pkt(1, 0);
      drain();
      chk("clamp_frames_at_256", stat_frames, 13);
      chk("clamp_busy_at_256", stat_busy, 0);

      // count changed 3 -> 2 inside a frame
      cfg_count = 9'd3;
      send_pkt(2, 0);
      cfg_count = 9'd2;
      send_pkt(3, 0);
      drain();
      chk("cfgchg_mid_frame_busy", stat_busy, 1);
      send_pkt(3, 1);
      drain();
      chk("cfgchg_frame3_done", stat_frames, 14);
      send_pkt(2, 0);
      send_pkt(4, 0);
      drain();
      chk("cfgchg_frame2_done", stat_frames, 15);

      // enable dropped mid-frame, then re-enabled mid-packet
      send_pkt(3, 0);
      cfg_enable = 1'b0;
      send_pkt(2, 0);
      send_pkt(2, 0);
      send_pkt(1, 0);
      send_beat(1'b0);
      send_beat(1'b0);
      drain();
      chk("disable_frames", stat_frames, 16);
      chk("disable_s_tready", s_axis_tready, 1);
      cfg_enable = 1'b1;
      send_beat(1'b0);
      send_beat(1'b1);
      send_pkt(2, 0);
      send_pkt(3, 0);
      drain();
      chk("reenable_frames", stat_frames, 17);

      // randomized traffic with random back-pressure
      rand_ready = 1'b1;
      for (int p = 0; p < 60; p++) begin
         if ($urandom_range(0, 3) == 0) cfg_count = 9'($urandom_range(0, 4));
         cfg_enable = ($urandom_range(0, 9) != 0);
         send_pkt($urandom_range(1, 6), 2);
      end

      // reset in the middle of a frame with data in flight
      cfg_enable = 1'b1;
      cfg_count  = 9'd3;
      send_pkt(4, 0);
      send_beat(1'b0);
      send_beat(1'b0);
      #2;
      axis_aresetn = 1'b0;
      repeat (2) @(negedge axis_aclk);
      chk("midrst_m_tvalid", m_axis_tvalid, 0);
      chk("midrst_m_tlast", m_axis_tlast, 0);
      chk("midrst_stat_frames", stat_frames, 0);
      chk("midrst_stat_busy", stat_busy, 0);
      chk("midrst_s_tready", s_axis_tready, 1);
      @(posedge axis_aclk);
      #1;
      axis_aresetn = 1'b1;
      send_beat(1'b0);
      send_beat(1'b1);
      for (int p = 0; p < 20; p++) begin
         if ($urandom_range(0, 3) == 0) cfg_count = 9'($urandom_range(1, 3));
         send_pkt($urandom_range(1, 5), 1);
      end
      rand_ready = 1'b0;
      drain();
      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_frames_vs_model", stat_frames, md_frames);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/axis_packet_combiner_rt.md
Name: axis_packet_combiner_rt

Overview:
- AXI4-Stream framer that merges N consecutive input packets into one output packet.
- Sits between a packetised source (ADC/DSP chain, tlast per block) and a DMA/FIFO sink.
- N is programmable at run time, not fixed at build time.
- Adds the following over a fixed-count combiner:
  - boundary-safe enable and reconfiguration;
  - a registered output stage (full throughput, no combinational ready path);
  - frame statistics.

Parameters:
- AXIS_TDATA_WIDTH, 32, data width in bits.
- MAX_PACKETS, 256, upper bound for cfg_count.
- DISCARD_FIRST_PACKET, 1:
  - 1: start in SYNC after reset and drop input until the first accepted tlast.
  - 0: start in IDLE.

Ports:
- axis_aclk  in  1  clock
- axis_aresetn  in  1  reset
- cfg_count  in  COUNT_W  input packets per output packet; COUNT_W = $clog2(MAX_PACKETS+1)
- cfg_enable  in  1  combiner enable, sampled at frame boundaries only
- s_axis_tready  out  1  slave ready
- s_axis_tdata  in  AXIS_TDATA_WIDTH  slave data
- s_axis_tvalid  in  1  slave valid
- s_axis_tlast  in  1  end of input packet
- m_axis_tready  in  1  master ready
- m_axis_tdata  out  AXIS_TDATA_WIDTH  master data
- m_axis_tvalid  out  1  master valid
- m_axis_tlast  out  1  end of combined packet
- stat_frames  out  32  count of completed output frames, wraps
- stat_busy  out  1  high while state == ACTIVE

Behaviour:
- Reset is axis_aresetn, asynchronous, active-low; the clock is axis_aclk. Reset values:
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0;
  - stat_frames = 0, stat_busy = 0;
  - s_axis_tready = 1 when output stage empty;
  - state = SYNC if DISCARD_FIRST_PACKET else IDLE.
- Accept = s_axis_tvalid & s_axis_tready. All state changes happen on accepted beats only.
- Effective count: eff = (cfg_count == 0) ? 1 : min(cfg_count, MAX_PACKETS).
- States:
  - SYNC: beats accepted and dropped. Accepted tlast -> IDLE.
  - IDLE (frame boundary):
    - Accepted beat with cfg_enable = 0: dropped. Non-tlast -> SYNC; tlast -> stay IDLE.
    - Accepted beat with cfg_enable = 1: forwarded; latch remaining = eff - 1.
      - tlast and remaining == 0: emit with m tlast, frame done, stay IDLE.
      - otherwise -> ACTIVE, where an in-frame tlast decrements remaining.
  - ACTIVE: all beats forwarded.
    - Input tlast with remaining == 0: forward with m tlast = 1 -> IDLE.
    - Input tlast with remaining != 0: remaining - 1, m tlast = 0.
- cfg_count and cfg_enable changes in ACTIVE are ignored until the next IDLE.
- Output stage is a 2-entry skid buffer:
  - latency 1 cycle (beat accepted at cycle N is valid at N+1 if buffer empty);
  - sustains 1 beat/cycle under continuous m_axis_tready;
  - s_axis_tready is registered (= buffer not full) and never depends combinationally on m_axis_tready.
- Dropped beats bypass the buffer; s_axis_tready is still gated by the buffer, so drops never reorder forwarded data.
- AXIS rule: once m_axis_tvalid = 1, data/last hold until m_axis_tready.
- stat_frames increments when a beat with m_axis_tlast = 1 completes on the master handshake. It wraps 0xFFFFFFFF -> 0.
- Reset mid-frame: the buffer is flushed with no partial tlast; state reloads per DISCARD_FIRST_PACKET.

Optional Feature:
- Macro AXIS_PACKET_COMBINER_TUSER_SOF_EN.
- When defined:
  - adds output port m_axis_tuser (1 bit);
  - m_axis_tuser is 1 on the first forwarded beat of each output frame, 0 otherwise;
  - it is stored in the skid buffer alongside data; reset 0.
- When undefined: the port is absent and the buffer width is AXIS_TDATA_WIDTH + 1.

Decomposition:
- Package axis_packet_combiner_pkg:
  - state enum {SYNC, IDLE, ACTIVE};
  - function clamp_count(cfg, max) returning eff.
- Sub-module axis_skid_buffer, parameter WIDTH: generic 2-entry registered slice, async active-low reset; reusable elsewhere.

Test Plan:
- cfg_count = 4, enable = 1, DISCARD = 0, 8-beat packets, m_tready = 1: 32-beat output frames; m_tlast only on beat 32; stat_frames = 2 after 64 beats; throughput 1 beat/cycle after 1-cycle latency.
- DISCARD = 1, stream begins mid-packet (beats 5..7 of 8): those 3 beats dropped, no m_tvalid; the next full packet is the first output beat.
- cfg_count = 0, tlast every beat: every output beat has m_tlast = 1, i.e. treated as 1.
- cfg_count = 300 with MAX_PACKETS = 256: clamps to 256.
- cfg_count changed 3 -> 2 mid-frame: the current frame completes with 3 packets; the next frame has 2.
- cfg_enable deasserted mid-frame: the current frame completes; subsequent packets are dropped; s_tready stays 1. Re-enable mid-packet: remaining beats of that packet dropped via SYNC, then framing resumes aligned.
- m_tready toggled 1-0 randomly, and reset asserted mid-frame: data order preserved; tdata/tlast stable while stalled; after reset, tvalid = 0 and stat_frames = 0, with no orphan tlast.
